// File: rtl/param_shift_register.sv
// Parametrised multi-mode shift register: DEPTH stages of WIDTH bits with
// forward/reverse shift, rotate, parallel load, synchronous clear and hold.
// Each stage carries a valid flag; count is the popcount of those flags and
// tap_q exposes one selectable stage.
module param_shift_register #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2,
    parameter int SELW  = $clog2(DEPTH),
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [2:0]               mode,
    input  logic [WIDTH-1:0]         sin_fwd,
    input  logic [WIDTH-1:0]         sin_rev,
    input  logic [WIDTH*DEPTH-1:0]   pload,
    input  logic [SELW-1:0]          tap_sel,
    output logic [WIDTH*DEPTH-1:0]   q_flat,
    output logic [WIDTH-1:0]         sout_fwd,
    output logic [WIDTH-1:0]         sout_rev,
    output logic [WIDTH-1:0]         tap_q,
    output logic [DEPTH-1:0]         valid,
    output logic [CNTW-1:0]          count
);

    localparam logic [2:0] MODE_HOLD      = 3'b000;
    localparam logic [2:0] MODE_SHIFT_FWD = 3'b001;
    localparam logic [2:0] MODE_SHIFT_REV = 3'b010;
    localparam logic [2:0] MODE_ROT_FWD   = 3'b011;
    localparam logic [2:0] MODE_ROT_REV   = 3'b100;
    localparam logic [2:0] MODE_LOAD      = 3'b101;
    localparam logic [2:0] MODE_CLEAR     = 3'b110;

    // tap_sel can address up to 2**SELW stages; entries past DEPTH read as zero
    localparam int TAPN = 2 ** SELW;

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [WIDTH-1:0] tap_arr [TAPN];

    // Next-state: mode is only decoded when en is high, so an unknown mode
    // while disabled cannot disturb the stored state. Mode 111 falls to hold.
    always_comb begin
        stage_d = stage_q;
        valid_d = valid_q;
        if (en) begin
            case (mode)
                MODE_HOLD: begin
                end
                MODE_SHIFT_FWD: begin
                    stage_d[0] = sin_fwd;
                    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
                    valid_d = {valid_q[DEPTH-2:0], 1'b1};
                end
                MODE_SHIFT_REV: begin
                    stage_d[DEPTH-1] = sin_rev;
                    for (int i = 0; i < DEPTH - 1; i++) stage_d[i] = stage_q[i+1];
                    valid_d = {1'b1, valid_q[DEPTH-1:1]};
                end
                MODE_ROT_FWD: begin
                    stage_d[0] = stage_q[DEPTH-1];
                    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
                    valid_d = {valid_q[DEPTH-2:0], valid_q[DEPTH-1]};
                end
                MODE_ROT_REV: begin
                    stage_d[DEPTH-1] = stage_q[0];
                    for (int i = 0; i < DEPTH - 1; i++) stage_d[i] = stage_q[i+1];
                    valid_d = {valid_q[0], valid_q[DEPTH-1:1]};
                end
                MODE_LOAD: begin
                    for (int i = 0; i < DEPTH; i++) stage_d[i] = pload[i*WIDTH +: WIDTH];
                    valid_d = '1;
                end
                MODE_CLEAR: begin
                    for (int i = 0; i < DEPTH; i++) stage_d[i] = '0;
                    valid_d = '0;
                end
                default: begin
                end
            endcase
        end
    end

    // State register; reset wipes every stage and valid flag immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            valid_q <= '0;
        end else begin
            stage_q <= stage_d;
            valid_q <= valid_d;
        end
    end

    // Flatten stages onto q_flat, stage i in slice i
    always_comb begin
        q_flat = '0;
        for (int i = 0; i < DEPTH; i++) q_flat[i*WIDTH +: WIDTH] = stage_q[i];
    end

    // Zero-padded tap table so out-of-range selects read 0
    always_comb begin
        for (int i = 0; i < TAPN; i++) tap_arr[i] = '0;
        for (int i = 0; i < DEPTH; i++) tap_arr[i] = stage_q[i];
    end

    // Occupancy is the popcount of the valid flags
    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) count = count + CNTW'(valid_q[i]);
    end

    assign tap_q    = tap_arr[tap_sel];
    assign sout_fwd = stage_q[DEPTH-1];
    assign sout_rev = stage_q[0];
    assign valid    = valid_q;

endmodule

// File: doc/param_shift_register.md
Name: param_shift_register

Overview:
- Parametrised, multi-mode successor to the two-flop serial shift register.
- DEPTH stages of WIDTH bits, with bidirectional serial shift, rotate, parallel load, synchronous clear and hold.
- Per-stage valid tracking, an occupancy count and a selectable tap output.
- Used as the general delay-line / serialiser primitive for datapath experiments and test benches in the VLSI flow.

Parameters:
- WIDTH, 1, bits per stage (>=1).
- DEPTH, 2, number of stages (>=2); defaults reproduce a 1-bit, 2-stage delay line.
- SELW, $clog2(DEPTH), width of tap_sel (derived, not overridden).
- CNTW, $clog2(DEPTH+1), width of count (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  operation enable; 0 = hold everything.
- mode  input  3  operation select (see Behaviour).
- sin_fwd  input  WIDTH  serial input entering stage 0 on forward shift.
- sin_rev  input  WIDTH  serial input entering stage DEPTH-1 on reverse shift.
- pload  input  WIDTH*DEPTH  parallel load data; slice [i*WIDTH +: WIDTH] goes to stage i.
- tap_sel  input  SELW  stage index driven onto tap_q.
- q_flat  output  WIDTH*DEPTH  all stages; slice i = stage i.
- sout_fwd  output  WIDTH  stage DEPTH-1.
- sout_rev  output  WIDTH  stage 0.
- tap_q  output  WIDTH  stage[tap_sel].
- valid  output  DEPTH  per-stage valid flags; bit i is for stage i.
- count  output  CNTW  number of set valid bits.

Behaviour:
- Reset: rst_n low asynchronously clears all stages and all valid bits. All outputs read 0 immediately, including count.
- Reset release: takes effect at the next rising edge with rst_n high.
- Reset mid-operation discards all contents; no partial-shift state survives.
- State update: all state changes on the rising clk edge, and only when en=1. With en=0, state holds regardless of mode.
- Outputs are combinational from state only; no input-to-output combinational path except tap_sel -> tap_q.
- mode encoding (en=1):
  - 000 HOLD: no change.
  - 001 SHIFT_FWD: stage0 <= sin_fwd; stage i <= stage i-1; valid shifts the same way with 1 entering valid[0]. Old stage DEPTH-1 is discarded.
  - 010 SHIFT_REV: stage DEPTH-1 <= sin_rev; stage i <= stage i+1; valid shifts the same way with 1 entering valid[DEPTH-1].
  - 011 ROT_FWD: stage0 <= old stage DEPTH-1, others as SHIFT_FWD. Valid rotates identically.
  - 100 ROT_REV: stage DEPTH-1 <= old stage 0, others as SHIFT_REV. Valid rotates identically.
  - 101 LOAD: stage i <= pload slice i; all valid bits <= 1.
  - 110 CLEAR: all stages <= 0; all valid <= 0 (synchronous).
  - 111: reserved, behaves as HOLD.
- All stage updates in one edge use pre-edge values; implement with nonblocking assignment semantics so stage order is irrelevant.
- Latency: a word presented on sin_fwd at enabled edge k appears on sout_fwd after edge k+DEPTH-1 (DEPTH enabled SHIFT_FWD edges in total). Same for sin_rev -> sout_rev.
- count = popcount(valid), saturating naturally at DEPTH. After DEPTH consecutive shifts from empty, count = DEPTH.
- tap_sel >= DEPTH (non-power-of-two DEPTH): tap_q = 0.
- Rotation preserves data and valid exactly; DEPTH rotations in either direction return the original state.
- X on mode while en=0 must not affect state.

Test Plan:
- WIDTH=8, DEPTH=4; assert rst_n low mid-stream after loading 0x11,0x22,0x33,0x44 -> q_flat=0, valid=0, count=0 before next clk edge.
- SHIFT_FWD with sin_fwd = 0xA1,0xB2,0xC3,0xD4 on 4 edges -> sout_fwd=0xA1, sout_rev=0xD4, valid=4'b1111, count=4. After edges 1-3, count reads 1,2,3.
- LOAD pload={0x44,0x33,0x22,0x11} then ROT_FWD x1 -> stage0=0x44, stage1=0x11. After 3 more ROT_FWD edges, state equals the loaded value. Repeat with ROT_REV.
- From empty, SHIFT_REV twice with sin_rev=0x5A,0x6B -> stage3=0x6B, stage2=0x5A, valid=4'b1100, count=2.
- en=0 for 5 edges with mode=001 and changing sin_fwd -> q_flat, valid and count unchanged. Mode 111 with en=1 also leaves state unchanged.
- After LOAD, CLEAR -> next edge q_flat=0, valid=0, count=0. Sweep tap_sel 0..3 before CLEAR -> tap_q = 0x11,0x22,0x33,0x44. Repeat at DEPTH=3 with tap_sel=3 -> tap_q=0.
